// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: consumer-side request ports and the shared memory port
// bundled for the round-robin memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready;
  logic                               mem_read_valid;
  logic [ADDR_BITS-1:0]               mem_read_address;
  logic                               mem_read_ready;
  logic [DATA_BITS-1:0]               mem_read_data;
  logic                               mem_write_valid;
  logic [ADDR_BITS-1:0]               mem_write_address;
  logic [DATA_BITS-1:0]               mem_write_data;
  logic                               mem_write_ready;
  logic                               busy;

  modport slave (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address,
    input  consumer_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data,
    output consumer_write_ready,
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    output busy
  );

  modport master (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address,
    output consumer_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data,
    input  consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter putting N consumer data-memory
// ports onto one memory port, one outstanding transaction at a time.
module mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter bit WRITE_ENABLE  = 1'b1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } state_t;

  state_t                   state;
  logic [CW-1:0]            rr_ptr;
  logic [CW-1:0]            ch;
  logic [CW-1:0]            ch_next;
  logic [CW-1:0]            gnt_idx;
  logic                     gnt_any;
  logic                     gnt_rd;
  logic [NUM_CONSUMERS-1:0] wr_req;

  assign wr_req = WRITE_ENABLE ? bus.consumer_write_valid : '0;
  assign ch_next = (int'(ch) == NUM_CONSUMERS - 1) ? '0 : ch + 1'b1;
  assign bus.busy = (state != IDLE);

  // Scan from the rr pointer with wrap; first requester wins, read first.
  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_rd  = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_CONSUMERS) j = j - NUM_CONSUMERS;
      if (!gnt_any && (bus.consumer_read_valid[j] || wr_req[j])) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(j);
        gnt_rd  = bus.consumer_read_valid[j];
      end
    end
  end

  // Grant / memory wait / relay sequencing with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                    <= IDLE;
      rr_ptr                   <= '0;
      ch                       <= '0;
      bus.mem_read_valid       <= 1'b0;
      bus.mem_read_address     <= '0;
      bus.mem_write_valid      <= 1'b0;
      bus.mem_write_address    <= '0;
      bus.mem_write_data       <= '0;
      bus.consumer_read_ready  <= '0;
      bus.consumer_read_data   <= '0;
      bus.consumer_write_ready <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            ch <= gnt_idx;
            if (gnt_rd) begin
              bus.mem_read_valid   <= 1'b1;
              bus.mem_read_address <=
                bus.consumer_read_address[gnt_idx*ADDR_BITS +: ADDR_BITS];
              state <= READ_WAIT;
            end else begin
              bus.mem_write_valid   <= 1'b1;
              bus.mem_write_address <=
                bus.consumer_write_address[gnt_idx*ADDR_BITS +: ADDR_BITS];
              bus.mem_write_data <=
                bus.consumer_write_data[gnt_idx*DATA_BITS +: DATA_BITS];
              state <= WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (bus.mem_read_ready) begin
            bus.mem_read_valid <= 1'b0;
            bus.consumer_read_data[ch*DATA_BITS +: DATA_BITS] <=
              bus.mem_read_data;
            bus.consumer_read_ready[ch] <= 1'b1;
            state <= READ_RELAY;
          end
        end
        WRITE_WAIT: begin
          if (bus.mem_write_ready) begin
            bus.mem_write_valid          <= 1'b0;
            bus.consumer_write_ready[ch] <= 1'b1;
            state <= WRITE_RELAY;
          end
        end
        READ_RELAY: begin
          if (!bus.consumer_read_valid[ch]) begin
            bus.consumer_read_ready[ch] <= 1'b0;
            rr_ptr <= ch_next;
            state  <= IDLE;
          end
        end
        WRITE_RELAY: begin
          if (!bus.consumer_write_valid[ch]) begin
            bus.consumer_write_ready[ch] <= 1'b0;
            rr_ptr <= ch_next;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of the round-robin memory arbiter,
// with a write-enabled instance and a read-only instance.
module tb_mem_arbiter;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(N)) a ();
  mem_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(N)) b ();

  mem_arbiter #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(N), .WRITE_ENABLE(1'b1)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(a.slave)
  );

  mem_arbiter #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(N), .WRITE_ENABLE(1'b0)
  ) u_dut_nw (
    .clk(clk), .reset(reset), .bus(b.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input int max);
    int n;
    n = 0;
    while (!a.mem_read_valid && n < max) begin
      tick();
      n++;
    end
    check("rd_req_seen", {31'd0, a.mem_read_valid}, 32'd1);
  endtask

  initial begin
    a.consumer_read_valid    = '0;
    a.consumer_read_address  = '0;
    a.consumer_write_valid   = '0;
    a.consumer_write_address = '0;
    a.consumer_write_data    = '0;
    a.mem_read_ready         = 1'b0;
    a.mem_read_data          = '0;
    a.mem_write_ready        = 1'b0;
    b.consumer_read_valid    = '0;
    b.consumer_read_address  = '0;
    b.consumer_write_valid   = '0;
    b.consumer_write_address = '0;
    b.consumer_write_data    = '0;
    b.mem_read_ready         = 1'b0;
    b.mem_read_data          = '0;
    b.mem_write_ready        = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_busy", {31'd0, a.busy}, 0);
    check("rst_mrv", {31'd0, a.mem_read_valid}, 0);
    check("rst_mwv", {31'd0, a.mem_write_valid}, 0);
    check("rst_crr", {28'd0, a.consumer_read_ready}, 0);
    check("rst_cwr", {28'd0, a.consumer_write_ready}, 0);
    check("rst_crd", a.consumer_read_data, 0);
    reset = 1'b1;
    tick();

    // single read on port 2
    a.consumer_read_address[23:16] = 8'h35;
    a.consumer_read_valid = 4'b0100;
    tick();
    check("p2_mrv", {31'd0, a.mem_read_valid}, 1);
    check("p2_addr", {24'd0, a.mem_read_address}, 32'h35);
    check("p2_busy", {31'd0, a.busy}, 1);
    a.mem_read_ready = 1'b1;
    a.mem_read_data  = 8'hA7;
    tick();
    a.mem_read_ready = 1'b0;
    check("p2_mrv_low", {31'd0, a.mem_read_valid}, 0);
    check("p2_ready", {28'd0, a.consumer_read_ready}, 32'h4);
    check("p2_data", {24'd0, a.consumer_read_data[23:16]}, 32'hA7);
    tick();
    check("p2_ready_hold", {28'd0, a.consumer_read_ready}, 32'h4);
    a.consumer_read_valid = 4'b0000;
    tick();
    check("p2_ready_drop", {28'd0, a.consumer_read_ready}, 0);
    check("p2_busy_drop", {31'd0, a.busy}, 0);
    check("p2_data_keep", {24'd0, a.consumer_read_data[23:16]}, 32'hA7);

    // all four ports read at once from reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    a.consumer_read_address = 32'h43424140;
    a.consumer_read_valid   = 4'hF;
    for (int g = 0; g < 5; g++) begin
      int p;
      p = g % N;
      wait_rd(8);
      check("rr_addr", {24'd0, a.mem_read_address}, 32'h40 + p);
      a.mem_read_ready = 1'b1;
      a.mem_read_data  = 8'(8'h90 + p);
      tick();
      a.mem_read_ready = 1'b0;
      check("rr_ready", {28'd0, a.consumer_read_ready}, 32'd1 << p);
      check("rr_data", {24'd0, a.consumer_read_data[p*8 +: 8]}, 32'h90 + p);
      a.consumer_read_valid[p] = 1'b0;
      tick();
      check("rr_ready_off", {28'd0, a.consumer_read_ready}, 0);
      a.consumer_read_valid[p] = 1'b1;
    end
    a.consumer_read_valid = 4'h0;
    tick();

    // write on port 1 with slow memory acceptance
    a.consumer_write_address[15:8] = 8'h10;
    a.consumer_write_data[15:8]    = 8'h5C;
    a.consumer_write_valid         = 4'b0010;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("wr_stable",
            {15'd0, a.mem_write_valid, a.mem_write_address, a.mem_write_data},
            {15'd0, 1'b1, 8'h10, 8'h5C});
      check("wr_no_ready", {28'd0, a.consumer_write_ready}, 0);
      tick();
    end
    a.mem_write_ready = 1'b1;
    tick();
    a.mem_write_ready = 1'b0;
    check("wr_mwv_low", {31'd0, a.mem_write_valid}, 0);
    check("wr_ready", {28'd0, a.consumer_write_ready}, 32'h2);
    a.consumer_write_valid = 4'b0000;
    tick();
    check("wr_ready_off", {28'd0, a.consumer_write_ready}, 0);
    check("wr_busy_off", {31'd0, a.busy}, 0);

    // port 3 with both read and write pending: read first
    a.consumer_read_address[31:24]  = 8'h77;
    a.consumer_write_address[31:24] = 8'h78;
    a.consumer_write_data[31:24]    = 8'h3C;
    a.consumer_read_valid  = 4'b1000;
    a.consumer_write_valid = 4'b1000;
    tick();
    check("both_rd", {30'd0, a.mem_read_valid, a.mem_write_valid}, 32'h2);
    check("both_raddr", {24'd0, a.mem_read_address}, 32'h77);
    a.mem_read_ready = 1'b1;
    a.mem_read_data  = 8'h11;
    tick();
    a.mem_read_ready = 1'b0;
    check("both_rready", {28'd0, a.consumer_read_ready}, 32'h8);
    check("both_wready0", {28'd0, a.consumer_write_ready}, 0);
    a.consumer_read_valid = 4'b0000;
    tick();
    tick();
    check("both_wr", {30'd0, a.mem_read_valid, a.mem_write_valid}, 32'h1);
    check("both_waddr", {16'd0, a.mem_write_address, a.mem_write_data},
          32'h783C);
    a.mem_write_ready = 1'b1;
    tick();
    a.mem_write_ready = 1'b0;
    check("both_wready", {28'd0, a.consumer_write_ready}, 32'h8);
    a.consumer_write_valid = 4'b0000;
    tick();
    check("both_idle", {31'd0, a.busy}, 0);

    // read-only instance ignores writes
    b.consumer_write_address[7:0] = 8'h22;
    b.consumer_write_data[7:0]    = 8'h99;
    b.consumer_write_valid        = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("nw_quiet",
            {28'd0, b.mem_write_valid, b.busy, b.consumer_write_ready[1:0]},
            0);
    end
    check("nw_wbus", {16'd0, b.mem_write_address, b.mem_write_data}, 0);
    check("nw_cwr", {28'd0, b.consumer_write_ready}, 0);
    b.consumer_write_valid = 4'b0000;

    // reset during an outstanding read
    a.consumer_read_address = 32'h00AA00BB;
    a.consumer_read_valid   = 4'b0100;
    tick();
    check("mid_rd_req", {31'd0, a.mem_read_valid}, 1);
    check("mid_rd_addr", {24'd0, a.mem_read_address}, 32'hAA);
    reset = 1'b0;
    #1;
    check("mid_rst_mrv", {31'd0, a.mem_read_valid}, 0);
    check("mid_rst_crr", {28'd0, a.consumer_read_ready}, 0);
    check("mid_rst_busy", {31'd0, a.busy}, 0);
    check("mid_rst_crd", a.consumer_read_data, 0);
    a.consumer_read_valid = 4'b0101;
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_addr", {24'd0, a.mem_read_address}, 32'hBB);
    a.mem_read_ready = 1'b1;
    a.mem_read_data  = 8'h42;
    tick();
    a.mem_read_ready = 1'b0;
    check("post_rst_ready", {28'd0, a.consumer_read_ready}, 32'h1);
    check("post_rst_data", {24'd0, a.consumer_read_data[7:0]}, 32'h42);
    a.consumer_read_valid = 4'b0000;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
